// File: rtl/tlb_op_fsm.sv
// ---------------------------------------------------------------------------
// tlb_op_fsm
//   Sequences the CP0 TLB instructions (TLBP, TLBR, TLBWI and optionally
//   TLBWR) against a shared TLB and owns the CP0 Index, EntryHi, EntryLo0
//   and EntryLo1 registers.
//
// Optional feature macro: TLBWR_EN
//   Defined   -> op_code 00 executes TLBWR (write at Random), and a Random
//                register counts down every cycle, visible on cp0_random.
//   Undefined -> op_code 00 is a no-op (IDLE -> DONE -> IDLE), cp0_random=0.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   op_valid/op_code       op request; op_ready high only in IDLE
//   op_done                one-cycle completion pulse
//   mtc0_we/addr/wdata     CP0 register writes (Index, EntryLo0/1, EntryHi)
//   cp0_*                  architectural register views
//   s1_*                   TLB search port (probe strobe + key, hit result)
//   wr, w_*                TLB write port
//   r_index, r_*           TLB read port
//   state_dbg              current FSM state encoding
//
// Handshake: an op is accepted on a rising edge where op_valid && op_ready.
// op_ready is high only in IDLE, so op_valid is ignored while an op is in
// flight and the requester must hold op_valid until it sees op_ready.
// ---------------------------------------------------------------------------
module tlb_op_fsm #(
    parameter int TLB_NUM = 16,
    parameter int IDX_W   = $clog2(TLB_NUM)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    output logic             op_ready,
    output logic             op_done,
    input  logic             mtc0_we,
    input  logic [4:0]       mtc0_addr,
    input  logic [31:0]      mtc0_wdata,
    output logic [31:0]      cp0_index,
    output logic [31:0]      cp0_entryhi,
    output logic [31:0]      cp0_entrylo0,
    output logic [31:0]      cp0_entrylo1,
    output logic [31:0]      cp0_random,
    output logic             s1_tlbp,
    output logic [18:0]      s1_vpn2,
    output logic             s1_odd_page,
    output logic [7:0]       s1_asid,
    input  logic             s1_found,
    input  logic [IDX_W-1:0] s1_index,
    output logic             wr,
    output logic [IDX_W-1:0] w_index,
    output logic [18:0]      w_vpn2,
    output logic [7:0]       w_asid,
    output logic             w_g,
    output logic [19:0]      w_pfn0,
    output logic [2:0]       w_c0,
    output logic             w_d0,
    output logic             w_v0,
    output logic [19:0]      w_pfn1,
    output logic [2:0]       w_c1,
    output logic             w_d1,
    output logic             w_v1,
    output logic [IDX_W-1:0] r_index,
    input  logic [18:0]      r_vpn2,
    input  logic [7:0]       r_asid,
    input  logic             r_g,
    input  logic [19:0]      r_pfn0,
    input  logic [2:0]       r_c0,
    input  logic             r_d0,
    input  logic             r_v0,
    input  logic [19:0]      r_pfn1,
    input  logic [2:0]       r_c1,
    input  logic             r_d1,
    input  logic             r_v1,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PROBE = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state;
    logic   ready_q, done_q, wr_q, tlbp_q;

    // CP0 register fields (only implemented bits are stored)
    logic             idx_p_q;
    logic [IDX_W-1:0] idx_q;
    logic [18:0]      vpn2_q;
    logic [7:0]       asid_q;
    logic [19:0]      pfn0_q, pfn1_q;
    logic [2:0]       c0_q, c1_q;
    logic             d0_q, v0_q, g0_q, d1_q, v1_q, g1_q;

`ifdef TLBWR_EN
    logic             wr_rand_q;   // current write uses Random as the index
    logic [IDX_W-1:0] random_q;
`endif

    // ---------------- FSM with registered strobes ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            tlbp_q  <= 1'b0;
`ifdef TLBWR_EN
            wr_rand_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid && ready_q) begin
                        ready_q <= 1'b0;
                        case (op_code)
                            2'b01: begin
                                state  <= S_PROBE;
                                tlbp_q <= 1'b1;
                            end
                            2'b10: state <= S_READ;
                            2'b11: begin
                                state <= S_WRITE;
                                wr_q  <= 1'b1;
`ifdef TLBWR_EN
                                wr_rand_q <= 1'b0;
`endif
                            end
                            default: begin
`ifdef TLBWR_EN
                                state     <= S_WRITE;
                                wr_q      <= 1'b1;
                                wr_rand_q <= 1'b1;
`else
                                state  <= S_DONE;
                                done_q <= 1'b1;
`endif
                            end
                        endcase
                    end
                end
                S_PROBE, S_READ, S_WRITE: begin
                    state  <= S_DONE;
                    done_q <= 1'b1;
                    tlbp_q <= 1'b0;
                    wr_q   <= 1'b0;
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                    wr_q    <= 1'b0;
                    tlbp_q  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- CP0 registers ----------------
    // mtc0 is applied first; the FSM updates below come later in the block
    // so they take precedence on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            idx_p_q <= 1'b0;
            idx_q   <= '0;
            vpn2_q  <= '0;
            asid_q  <= '0;
            pfn0_q  <= '0;
            c0_q    <= '0;
            d0_q    <= 1'b0;
            v0_q    <= 1'b0;
            g0_q    <= 1'b0;
            pfn1_q  <= '0;
            c1_q    <= '0;
            d1_q    <= 1'b0;
            v1_q    <= 1'b0;
            g1_q    <= 1'b0;
        end else begin
            if (mtc0_we) begin
                case (mtc0_addr)
                    5'd0:  idx_q <= mtc0_wdata[IDX_W-1:0];  // P is read-only
                    5'd2: begin
                        pfn0_q <= mtc0_wdata[25:6];
                        c0_q   <= mtc0_wdata[5:3];
                        d0_q   <= mtc0_wdata[2];
                        v0_q   <= mtc0_wdata[1];
                        g0_q   <= mtc0_wdata[0];
                    end
                    5'd3: begin
                        pfn1_q <= mtc0_wdata[25:6];
                        c1_q   <= mtc0_wdata[5:3];
                        d1_q   <= mtc0_wdata[2];
                        v1_q   <= mtc0_wdata[1];
                        g1_q   <= mtc0_wdata[0];
                    end
                    5'd10: begin
                        vpn2_q <= mtc0_wdata[31:13];
                        asid_q <= mtc0_wdata[7:0];
                    end
                    default: ;
                endcase
            end
            if (state == S_PROBE) begin
                idx_p_q <= ~s1_found;
                idx_q   <= s1_found ? s1_index : '0;
            end
            if (state == S_READ) begin
                vpn2_q <= r_vpn2;
                asid_q <= r_asid;
                pfn0_q <= r_pfn0;
                c0_q   <= r_c0;
                d0_q   <= r_d0;
                v0_q   <= r_v0;
                g0_q   <= r_g;
                pfn1_q <= r_pfn1;
                c1_q   <= r_c1;
                d1_q   <= r_d1;
                v1_q   <= r_v1;
                g1_q   <= r_g;
            end
        end
    end

`ifdef TLBWR_EN
    // Free-running down counter, wraps 0 -> TLB_NUM-1.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            random_q <= IDX_W'(TLB_NUM - 1);
        end else if (random_q == '0) begin
            random_q <= IDX_W'(TLB_NUM - 1);
        end else begin
            random_q <= random_q - 1'b1;
        end
    end
    assign cp0_random = {{(32-IDX_W){1'b0}}, random_q};
    assign w_index    = wr_rand_q ? random_q : idx_q;
`else
    assign cp0_random = 32'd0;
    assign w_index    = idx_q;
`endif

    // ---------------- outputs ----------------
    assign op_ready  = ready_q;
    assign op_done   = done_q;
    assign s1_tlbp   = tlbp_q;
    // Gating with resetn keeps a reset that lands in the WRITE cycle from
    // committing the write at the next edge.
    assign wr        = wr_q & resetn;
    assign state_dbg = state;

    assign cp0_index    = {idx_p_q, {(31-IDX_W){1'b0}}, idx_q};
    assign cp0_entryhi  = {vpn2_q, 5'd0, asid_q};
    assign cp0_entrylo0 = {6'd0, pfn0_q, c0_q, d0_q, v0_q, g0_q};
    assign cp0_entrylo1 = {6'd0, pfn1_q, c1_q, d1_q, v1_q, g1_q};

    assign s1_vpn2     = vpn2_q;
    assign s1_asid     = asid_q;
    assign s1_odd_page = 1'b0;

    assign w_vpn2 = vpn2_q;
    assign w_asid = asid_q;
    assign w_g    = g0_q & g1_q;
    assign w_pfn0 = pfn0_q;
    assign w_c0   = c0_q;
    assign w_d0   = d0_q;
    assign w_v0   = v0_q;
    assign w_pfn1 = pfn1_q;
    assign w_c1   = c1_q;
    assign w_d1   = d1_q;
    assign w_v1   = v1_q;

    assign r_index = idx_q;

endmodule

// File: tb/tb_tlb_op_fsm.sv
// Directed bench for tlb_op_fsm: driver tasks issue ops and push expected
// register/write-port values; a negedge monitor pops and compares them.
module tb_tlb_op_fsm;
  localparam int IDX_W = 4;
`ifdef TLBWR_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic clk, resetn;
  logic op_valid;
  logic [1:0] op_code;
  logic op_ready, op_done;
  logic mtc0_we;
  logic [4:0] mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic [31:0] cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_random;
  logic s1_tlbp, s1_odd_page, s1_found;
  logic [18:0] s1_vpn2;
  logic [7:0] s1_asid;
  logic [IDX_W-1:0] s1_index;
  logic wr;
  logic [IDX_W-1:0] w_index, r_index;
  logic [18:0] w_vpn2, r_vpn2;
  logic [7:0] w_asid, r_asid;
  logic w_g, r_g;
  logic [19:0] w_pfn0, w_pfn1, r_pfn0, r_pfn1;
  logic [2:0] w_c0, w_c1, r_c0, r_c1;
  logic w_d0, w_v0, w_d1, w_v1, r_d0, r_v0, r_d1, r_v1;
  logic [2:0] state_dbg;

  tlb_op_fsm dut (
    .clk(clk), .resetn(resetn),
    .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready), .op_done(op_done),
    .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
    .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0),
    .cp0_entrylo1(cp0_entrylo1), .cp0_random(cp0_random),
    .s1_tlbp(s1_tlbp), .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index),
    .wr(wr), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [81:0]  exp_wr_q[$];
  logic [127:0] exp_reg_q[$];
  logic [1:0]   kind_q[$];
  int           hs_q[$];
  int           hs_log[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [81:0] pack_w(
      input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
      input logic [19:0] p0, input logic [19:0] p1, input logic [2:0] c0, input logic [2:0] c1,
      input logic d0, input logic v0, input logic d1, input logic v1);
    return {idx, vpn2, asid, g, p0, p1, c0, c1, d0, v0, d1, v1};
  endfunction

  // ---------------- monitor ----------------
  bit in_work, in_done, exp_tlbp, exp_wr;
  logic [1:0] cur_kind;
  int done_ofs;

  always @(negedge clk) begin
    if (!resetn) begin
      if (hs_q.size() > 0) check("wr_blocked_in_reset", wr, 1'b0);
      hs_q.delete(); kind_q.delete(); exp_wr_q.delete(); exp_reg_q.delete();
    end else begin
      cur_kind = (kind_q.size() > 0) ? kind_q[0] : 2'b10;
      done_ofs = (cur_kind == 2'b00 && !WR_EN) ? 1 : 2;
      in_work  = (hs_q.size() > 0) && (cyc == hs_q[0] + 1) && (done_ofs == 2);
      in_done  = (hs_q.size() > 0) && (cyc == hs_q[0] + done_ofs);
      exp_tlbp = in_work && (cur_kind == 2'b01);
      exp_wr   = in_work && (cur_kind == 2'b11 || (cur_kind == 2'b00 && WR_EN));
      if (exp_tlbp || s1_tlbp) check("s1_tlbp", s1_tlbp, exp_tlbp);
      if (exp_wr || wr) begin
        check("wr", wr, exp_wr);
        if (wr && exp_wr && exp_wr_q.size() > 0)
          check("w_fields", pack_w(w_index, w_vpn2, w_asid, w_g, w_pfn0, w_pfn1,
                                   w_c0, w_c1, w_d0, w_v0, w_d1, w_v1), exp_wr_q.pop_front());
      end
      if (hs_q.size() > 0) check("op_ready_busy", op_ready, 1'b0);
      if (in_done || op_done) begin
        check("op_done", op_done, in_done);
        if (in_done) begin
          void'(hs_q.pop_front());
          if (kind_q.size() > 0) void'(kind_q.pop_front());
          if (exp_reg_q.size() > 0)
            check("cp0_regs", {cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1},
                  exp_reg_q.pop_front());
        end
      end
      if (op_valid && op_ready) begin
        hs_q.push_back(cyc);
        hs_log.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    mtc0_we = 1'b1; mtc0_addr = addr; mtc0_wdata = data;
    tick();
    mtc0_we = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!op_ready && n < 20) begin tick(); n++; end
    if (!op_ready) check("wait_ready_timeout", op_ready, 1'b1);
  endtask

  // Returns at the start of the cycle after the handshake (the work cycle).
  task automatic issue(input logic [1:0] code, input logic [127:0] regs,
                       input bit has_wr, input logic [81:0] wexp);
    wait_ready();
    kind_q.push_back(code);
    exp_reg_q.push_back(regs);
    if (has_wr) exp_wr_q.push_back(wexp);
    op_valid = 1'b1; op_code = code;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((hs_q.size() > 0 || !op_ready) && n < 20) begin tick(); n++; end
    check("drain_pending_ops", hs_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  logic [127:0] regs_a, regs_r;
  logic [81:0]  w_a, w_r;
  int hs_before;

  initial begin
    resetn = 1'b0; op_valid = 1'b0; op_code = 2'b00;
    mtc0_we = 1'b0; mtc0_addr = '0; mtc0_wdata = '0;
    s1_found = 1'b0; s1_index = '0;
    r_vpn2 = '0; r_asid = '0; r_g = 1'b0; r_pfn0 = '0; r_pfn1 = '0;
    r_c0 = '0; r_c1 = '0; r_d0 = 1'b0; r_v0 = 1'b0; r_d1 = 1'b0; r_v1 = 1'b0;

    repeat (3) tick();
    check("rst_regs", {cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1}, 128'd0);
    check("rst_strobes", {op_ready, op_done, wr, s1_tlbp}, 4'b1000);
    check("rst_random", cp0_random, WR_EN ? 32'd15 : 32'd0);
    resetn = 1'b1;

    // TLBWI with hand-loaded registers
    mtc0(5'd10, 32'h0000_4005);
    mtc0(5'd2,  32'h0000_0047);
    mtc0(5'd3,  32'h0000_0087);
    mtc0(5'd0,  32'h0000_0005);
    regs_a = {32'h0000_0005, 32'h0000_4005, 32'h0000_0047, 32'h0000_0087};
    check("mtc0_readback", {cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1}, regs_a);
    w_a = pack_w(4'd5, 19'h2, 8'h05, 1'b1, 20'h1, 20'h2, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    issue(2'b11, regs_a, 1'b1, w_a);
    drain();

    // TLBP hit at 5 (Index cleared first), then a miss
    mtc0(5'd0, 32'h0);
    s1_found = 1'b1; s1_index = 4'd5;
    issue(2'b01, regs_a, 1'b0, '0);
    drain();
    s1_found = 1'b0; s1_index = 4'd9;
    issue(2'b01, {32'h8000_0000, regs_a[95:0]}, 1'b0, '0);
    drain();

    // TLBR at Index=3; P stays set since mtc0 cannot write it
    mtc0(5'd0, 32'h0000_0003);
    check("index_p_readonly", cp0_index, 32'h8000_0003);
    check("r_index", r_index, 4'd3);
    r_vpn2 = 19'h7FFFF; r_asid = 8'hAA; r_g = 1'b1;
    r_pfn0 = 20'hFFFFF; r_c0 = 3'd3; r_d0 = 1'b1; r_v0 = 1'b1;
    r_pfn1 = 20'h12345; r_c1 = 3'd2; r_d1 = 1'b0; r_v1 = 1'b1;
    regs_r = {32'h8000_0003, 32'hFFFF_E0AA, 32'h03FF_FFDF, 32'h0048_D153};
    issue(2'b10, regs_r, 1'b0, '0);
    drain();
    check("s1_key", {s1_vpn2, s1_asid, s1_odd_page}, {19'h7FFFF, 8'hAA, 1'b0});

    // mtc0 Index collides with PROBE update: probe result wins
    s1_found = 1'b1; s1_index = 4'd2;
    issue(2'b01, {32'h0000_0002, regs_r[95:0]}, 1'b0, '0);
    mtc0(5'd0, 32'h0000_0009);
    drain();
    mtc0(5'd0, 32'hFFFF_FFFF);
    check("index_mask", cp0_index, 32'h0000_000F);

    // op_valid held high: three TLBWI handshakes, 3 cycles apart
    regs_a = {32'h0000_000F, regs_r[95:0]};
    w_r = pack_w(4'hF, 19'h7FFFF, 8'hAA, 1'b1, 20'hFFFFF, 20'h12345,
                 3'd3, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    hs_before = hs_log.size();
    for (int i = 0; i < 3; i++) begin
      kind_q.push_back(2'b11); exp_reg_q.push_back(regs_a); exp_wr_q.push_back(w_r);
    end
    op_valid = 1'b1; op_code = 2'b11;
    repeat (7) tick();
    op_valid = 1'b0;
    drain();
    check("stream_hs_count", hs_log.size() - hs_before, 3);
    if (hs_log.size() - hs_before == 3) begin
      check("stream_gap0", hs_log[hs_before+1] - hs_log[hs_before], 3);
      check("stream_gap1", hs_log[hs_before+2] - hs_log[hs_before+1], 3);
    end

`ifdef TLBWR_EN
    begin
      int n = 0;
      while (cp0_random != 32'd0 && n < 40) begin tick(); n++; end
      check("random_reach0", cp0_random, 32'd0);
      tick();
      check("random_wrap", cp0_random, 32'd15);
      n = 0;
      while (cp0_random != 32'd8 && n < 40) begin tick(); n++; end
      check("random_at8", cp0_random, 32'd8);
      issue(2'b00, regs_a, 1'b1, pack_w(4'd7, 19'h7FFFF, 8'hAA, 1'b1, 20'hFFFFF, 20'h12345,
                                        3'd3, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1));
      drain();
    end
`else
    // reserved op: no-op that still pulses op_done
    issue(2'b00, regs_a, 1'b0, '0);
    drain();
`endif

    // reset during the WRITE cycle aborts the op
    issue(2'b11, regs_a, 1'b1, w_r);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("abort_strobes", {op_ready, op_done, wr}, 3'b100);
    check("abort_regs", cp0_index, 32'd0);
    repeat (3) tick();
    check("abort_no_ops", hs_q.size(), 0);

    check("exp_wr_left", exp_wr_q.size(), 0);
    check("exp_reg_left", exp_reg_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
